// File: rtl/spi_flash_boot_loader.sv
// Boot-time copier: one continuous SPI READ (0x03) from flash, WORD_COUNT little-endian words into SPRAM.
// done rises on clk edge 2 + 2*CLK_DIV*(32 + 32*WORD_COUNT), counting the first rising edge after rstn release as edge 1.
module spi_flash_boot_loader #(
  parameter logic [23:0] FLASH_ADDR = 24'h100000,
  parameter int          WORD_COUNT = 8192,
  parameter int          ADDR_W     = 15,
  parameter int          CLK_DIV    = 1
) (
  input  logic              clk,
  input  logic              rstn,
  output logic              spi_cs,
  output logic              spi_clk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_din,
  output logic              busy,
  output logic              done
);

  localparam int                DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORD_COUNT - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [31:0]       HEADER    = {8'h03, FLASH_ADDR};

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    DATA = 3'd2,
    FIN  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t             state_r, state_nxt;
  logic [DIV_W-1:0]   div_cnt_r;
  logic [4:0]         bit_cnt_r;
  logic [ADDR_W-1:0]  word_cnt_r;
  logic [31:0]        hdr_r;
  logic [30:0]        rx_r;
  logic               spi_cs_r, spi_clk_r, spi_mosi_r, sram_we_r, busy_r, done_r;
  logic [ADDR_W-1:0]  sram_addr_r;
  logic [31:0]        sram_din_r;

  logic               shifting_s, phase_end_s, rise_s, fall_s, last_bit_s, last_word_s;
  logic [31:0]        rx_word_s;
  logic               spi_cs_nxt, busy_nxt, done_nxt, sram_we_nxt;

  // First flash byte of a word arrives in the top byte of the shift register.
  function automatic logic [31:0] swap_bytes(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  assign shifting_s  = (state_r == CMD) || (state_r == DATA);
  assign phase_end_s = shifting_s && (div_cnt_r == DIV_LAST);
  assign rise_s      = phase_end_s && !spi_clk_r;
  assign fall_s      = phase_end_s && spi_clk_r;
  assign last_bit_s  = (bit_cnt_r == 5'd31);
  assign last_word_s = (word_cnt_r == LAST_WORD);
  assign rx_word_s   = {rx_r, spi_miso};

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state logic; CMD flows into DATA with no gap on the same bit boundary.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE: state_nxt = CMD;
      CMD: begin
        if (fall_s && last_bit_s) begin
          state_nxt = DATA;
        end else begin
          state_nxt = CMD;
        end
      end
      DATA: begin
        if (fall_s && last_bit_s && last_word_s) begin
          state_nxt = FIN;
        end else begin
          state_nxt = DATA;
        end
      end
      FIN:     state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: next values of the registered control outputs.
  always_comb begin
    spi_cs_nxt  = 1'b1;
    busy_nxt    = 1'b0;
    done_nxt    = 1'b0;
    sram_we_nxt = (state_r == DATA) && rise_s && last_bit_s;
    case (state_r)
      IDLE, CMD, DATA: begin
        spi_cs_nxt = 1'b0;
        busy_nxt   = 1'b1;
        done_nxt   = 1'b0;
      end
      FIN, DONE: begin
        spi_cs_nxt = 1'b1;
        busy_nxt   = 1'b0;
        done_nxt   = 1'b1;
      end
      default: begin
        spi_cs_nxt = 1'b1;
        busy_nxt   = 1'b0;
        done_nxt   = 1'b0;
      end
    endcase
  end

  // SPI shifter, bit/word counters and SPRAM write port.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_cnt_r   <= '0;
      bit_cnt_r   <= 5'd0;
      word_cnt_r  <= '0;
      hdr_r       <= 32'd0;
      rx_r        <= 31'd0;
      spi_cs_r    <= 1'b1;
      spi_clk_r   <= 1'b0;
      spi_mosi_r  <= 1'b0;
      sram_we_r   <= 1'b0;
      sram_addr_r <= '0;
      sram_din_r  <= 32'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      spi_cs_r  <= spi_cs_nxt;
      busy_r    <= busy_nxt;
      done_r    <= done_nxt;
      sram_we_r <= sram_we_nxt;
      if (state_r == IDLE) begin
        div_cnt_r  <= '0;
        bit_cnt_r  <= 5'd0;
        word_cnt_r <= '0;
        hdr_r      <= {HEADER[30:0], 1'b0};
        spi_mosi_r <= HEADER[31];
        spi_clk_r  <= 1'b0;
      end else if (rise_s) begin
        div_cnt_r <= '0;
        spi_clk_r <= 1'b1;
        if (state_r == DATA) begin
          rx_r <= rx_word_s[30:0];
        end else begin
          rx_r <= rx_r;
        end
      end else if (fall_s) begin
        div_cnt_r <= '0;
        spi_clk_r <= 1'b0;
        bit_cnt_r <= bit_cnt_r + 5'd1;
        // After the 32nd header bit the shifter holds zeros, so mosi idles low in DATA.
        if (state_r == CMD) begin
          spi_mosi_r <= hdr_r[31];
          hdr_r      <= {hdr_r[30:0], 1'b0};
        end else begin
          spi_mosi_r <= 1'b0;
        end
        if ((state_r == DATA) && last_bit_s && !last_word_s) begin
          word_cnt_r <= word_cnt_r + ADDR_ONE;
        end else begin
          word_cnt_r <= word_cnt_r;
        end
      end else if (shifting_s) begin
        div_cnt_r <= div_cnt_r + DIV_ONE;
      end else begin
        div_cnt_r <= '0;
      end
      if (sram_we_nxt) begin
        sram_din_r <= swap_bytes(rx_word_s);
      end else begin
        sram_din_r <= sram_din_r;
      end
      // Address advances after each strobe but parks on the last word.
      if (sram_we_r && (sram_addr_r != LAST_WORD)) begin
        sram_addr_r <= sram_addr_r + ADDR_ONE;
      end else begin
        sram_addr_r <= sram_addr_r;
      end
    end
  end

  assign spi_cs    = spi_cs_r;
  assign spi_clk   = spi_clk_r;
  assign spi_mosi  = spi_mosi_r;
  assign sram_we   = sram_we_r;
  assign sram_addr = sram_addr_r;
  assign sram_din  = sram_din_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_spi_flash_boot_loader.sv
// Directed bench: four loader instances (2w/div1, 2w/div3, 1w/div1, 8w/div1 with mid-copy reset) against flash models.
module tb_spi_flash_boot_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn_abc = 1'b0;
  logic rstn_d   = 1'b0;
  int   n_total  = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Flash image: instance 2 holds DE AD BE EF, the others 11 22 .. 88 then a filler ramp.
  function automatic logic [7:0] img_byte(input int g, input int i);
    if (g == 2) begin
      case (i)
        0:       return 8'hDE;
        1:       return 8'hAD;
        2:       return 8'hBE;
        3:       return 8'hEF;
        default: return 8'h00;
      endcase
    end else if (i < 8) begin
      return 8'(17 * (i + 1));
    end else begin
      return 8'(i * 7 + 3);
    end
  endfunction

  function automatic logic img_bit(input int g, input int k);
    logic [7:0] b;
    b = img_byte(g, k / 8);
    return b[7 - (k % 8)];
  endfunction

  function automatic logic [31:0] exp_word(input int g, input int k);
    return {img_byte(g, 4*k+3), img_byte(g, 4*k+2), img_byte(g, 4*k+1), img_byte(g, 4*k)};
  endfunction

  for (genvar g = 0; g < 4; g++) begin : blk
    localparam int WC = (g == 3) ? 8 : (g == 2) ? 1 : 2;
    localparam int CD = (g == 1) ? 3 : 1;

    logic        rstn_g;
    logic        cs, sclk, mosi, we, busy, done;
    logic        miso = 1'b0;
    logic [14:0] addr;
    logic [31:0] din;

    assign rstn_g = (g == 3) ? rstn_d : rstn_abc;

    spi_flash_boot_loader #(
      .FLASH_ADDR (24'h100000),
      .WORD_COUNT (WC),
      .ADDR_W     (15),
      .CLK_DIV    (CD)
    ) u_dut (
      .clk       (clk),
      .rstn      (rstn_g),
      .spi_cs    (cs),
      .spi_clk   (sclk),
      .spi_mosi  (mosi),
      .spi_miso  (miso),
      .sram_we   (we),
      .sram_addr (addr),
      .sram_din  (din),
      .busy      (busy),
      .done      (done)
    );

    int          fcnt    = 0;
    int          cmd_cnt = 0;
    logic [31:0] fcmd    = 32'd0;

    always @(posedge sclk or posedge cs) begin
      if (cs) begin
        fcnt <= 0;
      end else begin
        if (fcnt < 32) fcmd <= {fcmd[30:0], mosi};
        if (fcnt == 31) cmd_cnt <= cmd_cnt + 1;
        fcnt <= fcnt + 1;
      end
    end

    always @(negedge sclk) begin
      if (!cs && fcnt >= 32)
        miso <= img_bit(g, (int'(fcmd[23:0]) - 32'h100000) * 8 + (fcnt - 32));
    end

    int          cyc = 0;
    always @(posedge clk or negedge rstn_g) begin
      if (!rstn_g) cyc <= 0;
      else         cyc <= cyc + 1;
    end

    logic [14:0] la [0:15];
    logic [31:0] ld [0:15];
    int          n = 0, viol = 0, period = 0, last_rise = 0, done_cyc = 0;
    logic        we_prev = 1'b0, sclk_prev = 1'b0, mosi_prev = 1'b0;

    always @(negedge clk) begin
      if (we && n < 16) begin
        la[n] <= addr;
        ld[n] <= din;
        n     <= n + 1;
      end
      viol <= viol + int'(we && we_prev) + int'(cs && sclk)
                   + int'(sclk && sclk_prev && (mosi != mosi_prev))
                   + int'(done && (!cs || sclk || we || busy));
      we_prev   <= we;
      sclk_prev <= sclk;
      mosi_prev <= mosi;
      if (sclk && !sclk_prev) begin
        period    <= cyc - last_rise;
        last_rise <= cyc;
      end
      if (!rstn_g)                    done_cyc <= 0;
      else if (done && done_cyc == 0) done_cyc <= cyc;
    end
  end

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outs_a", 64'({blk[0].cs, blk[0].sclk, blk[0].mosi, blk[0].we, blk[0].addr,
                             blk[0].din, blk[0].busy, blk[0].done}),
          64'({1'b1, 1'b0, 1'b0, 1'b0, 15'd0, 32'd0, 1'b0, 1'b0}));
    check("rst_outs_d", 64'({blk[3].cs, blk[3].sclk, blk[3].we, blk[3].busy, blk[3].done}),
          64'(5'b10000));
    @(negedge clk);
    rstn_abc = 1'b1;
    rstn_d   = 1'b1;
    #1;
    check("idle_cs_high", 64'(blk[0].cs), 64'(1'b1));
    @(posedge clk);
    #1;
    check("cmd_start", 64'({blk[0].cs, blk[0].busy, blk[0].mosi, blk[0].sclk}), 64'(4'b0100));

    k = 0;
    while (blk[3].n < 2 && k < 1000) begin
      @(posedge clk);
      k++;
    end
    check("d_two_words", 64'(blk[3].n), 64'(2));
    repeat (20) @(posedge clk);
    #2 rstn_d = 1'b0;
    #1;
    check("d_rst_async", 64'({blk[3].cs, blk[3].we, blk[3].busy, blk[3].sclk, blk[3].done}),
          64'(5'b10000));
    repeat (2) @(negedge clk);
    rstn_d = 1'b1;

    k = 0;
    while (!(blk[0].done && blk[1].done && blk[2].done && blk[3].done) && k < 3000) begin
      @(posedge clk);
      k++;
    end
    check("all_done", 64'({blk[3].done, blk[2].done, blk[1].done, blk[0].done}), 64'(4'hF));
    repeat (20) @(posedge clk);
    #1;

    check("a_cmd",      64'(blk[0].fcmd), 64'(32'h03100000));
    check("a_nwrites",  64'(blk[0].n), 64'(2));
    check("a_addr0",    64'(blk[0].la[0]), 64'(0));
    check("a_data0",    64'(blk[0].ld[0]), 64'(32'h44332211));
    check("a_addr1",    64'(blk[0].la[1]), 64'(1));
    check("a_data1",    64'(blk[0].ld[1]), 64'(32'h88776655));
    check("a_final",    64'({blk[0].cs, blk[0].busy, blk[0].done, blk[0].addr}), 64'({3'b101, 15'd1}));
    check("a_done_cyc", 64'(blk[0].done_cyc), 64'(194));
    check("a_period",   64'(blk[0].period), 64'(2));

    check("b_nwrites",  64'(blk[1].n), 64'(2));
    check("b_data0",    64'(blk[1].ld[0]), 64'(32'h44332211));
    check("b_data1",    64'(blk[1].ld[1]), 64'(32'h88776655));
    check("b_done_cyc", 64'(blk[1].done_cyc), 64'(578));
    check("b_period",   64'(blk[1].period), 64'(6));

    check("c_nwrites",  64'(blk[2].n), 64'(1));
    check("c_addr0",    64'(blk[2].la[0]), 64'(0));
    check("c_data0",    64'(blk[2].ld[0]), 64'(32'hEFBEADDE));
    check("c_final",    64'({blk[2].cs, blk[2].busy, blk[2].done, blk[2].addr}), 64'({3'b101, 15'd0}));
    check("c_done_cyc", 64'(blk[2].done_cyc), 64'(130));

    check("d_cmd_count", 64'(blk[3].cmd_cnt), 64'(2));
    check("d_nwrites",   64'(blk[3].n), 64'(10));
    for (int i = 0; i < 10; i++) begin
      check($sformatf("d_addr%0d", i), 64'(blk[3].la[i]), 64'((i < 2) ? i : i - 2));
      check($sformatf("d_data%0d", i), 64'(blk[3].ld[i]), 64'(exp_word(3, (i < 2) ? i : i - 2)));
    end
    check("d_final",    64'({blk[3].cs, blk[3].busy, blk[3].done, blk[3].addr}), 64'({3'b101, 15'd7}));
    check("d_done_cyc", 64'(blk[3].done_cyc), 64'(578));

    for (int g = 0; g < 4; g++) begin
      int v;
      case (g)
        0:       v = blk[0].viol;
        1:       v = blk[1].viol;
        2:       v = blk[2].viol;
        default: v = blk[3].viol;
      endcase
      check($sformatf("protocol_%0d", g), 64'(v), 64'(0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
